cmul_scheduler: RTL and testbench

- Sequences a single shared 8x8 unsigned shift-add multiplier to compute one signed complex product (a_re + j·a_im)·(b_re + j·b_im) for the FFT butterfly.
- Issues the four partial products (ar·br, ai·bi, ar·bi, ai·br) to the multiplier one at a time.
- Applies operand signs around the unsigned multiplier.
- Accumulates the signed real and imaginary results and presents them through valid/ready handshakes.

---
 rtl/cmul_scheduler_pkg.sv | 61 ++++++
 rtl/cmul_scheduler_if.sv | 35 +++
 rtl/cmul_scheduler_sign_unit.sv | 30 +++
 rtl/cmul_scheduler.sv | 161 ++++++++++++++++
 tb/tb_cmul_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmul_scheduler_pkg.sv
// Shared widths, FSM encoding and partial-product tables for the complex-multiply scheduler.
// Pure declarations: no logic, no latency.
package cmul_scheduler_pkg;

  localparam int W_IN         = 8;
  localparam int W_PROD       = 2 * W_IN;
  localparam int W_ACC        = 2 * W_IN + 1;
  localparam int MULT_LAT_DEF = 10;
  localparam int TIMEOUT_DEF  = 32;

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_e;

  typedef logic [1:0] pp_idx_t;

  localparam pp_idx_t PP_RR   = 2'd0;  // ar * br
  localparam pp_idx_t PP_II   = 2'd1;  // ai * bi
  localparam pp_idx_t PP_RI   = 2'd2;  // ar * bi
  localparam pp_idx_t PP_IR   = 2'd3;  // ai * br
  localparam pp_idx_t PP_LAST = PP_IR;

  typedef enum logic [1:0] {
    ACC_ADD_RE,
    ACC_SUB_RE,
    ACC_ADD_IM
  } acc_op_e;

  typedef struct packed {
    logic signed [W_IN-1:0] a_re;
    logic signed [W_IN-1:0] a_im;
    logic signed [W_IN-1:0] b_re;
    logic signed [W_IN-1:0] b_im;
  } operands_t;

  function automatic acc_op_e acc_op(input pp_idx_t idx);
    acc_op_e op;
    case (idx)
      PP_RR:   op = ACC_ADD_RE;
      PP_II:   op = ACC_SUB_RE;
      PP_RI:   op = ACC_ADD_IM;
      PP_IR:   op = ACC_ADD_IM;
      default: op = ACC_ADD_IM;
    endcase
    return op;
  endfunction

  function automatic logic sel_a_im(input pp_idx_t idx);
    return (idx == PP_II) || (idx == PP_IR);
  endfunction

  function automatic logic sel_b_im(input pp_idx_t idx);
    return (idx == PP_II) || (idx == PP_RI);
  endfunction

endpackage

// File: rtl/cmul_scheduler_if.sv
// Operand/result handshakes plus the shared-multiplier side-band of the scheduler.
// slave = scheduler view; master = the environment (producer, consumer and multiplier).
interface cmul_scheduler_if;
  import cmul_scheduler_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [W_IN-1:0]   a_re;
  logic signed [W_IN-1:0]   a_im;
  logic signed [W_IN-1:0]   b_re;
  logic signed [W_IN-1:0]   b_im;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [W_ACC-1:0]  prod_re;
  logic signed [W_ACC-1:0]  prod_im;
  logic                     err;

  logic                     mult_start;
  logic [W_IN-1:0]          mult_a;
  logic [W_IN-1:0]          mult_b;
  logic [W_PROD-1:0]        mult_out;
  logic                     mult_valid;

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, out_ready, mult_out, mult_valid,
    output in_ready, out_valid, prod_re, prod_im, err, mult_start, mult_a, mult_b
  );

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, out_ready, mult_out, mult_valid,
    input  in_ready, out_valid, prod_re, prod_im, err, mult_start, mult_a, mult_b
  );

endinterface

// File: rtl/cmul_scheduler_sign_unit.sv
// Sign handling around the unsigned multiplier: operand magnitudes + product sign,
// and signed re-extension of the returned magnitude. Purely combinational.
module cmul_sign_unit
  import cmul_scheduler_pkg::*;
(
  input  logic signed [W_IN-1:0]  x_i,
  input  logic signed [W_IN-1:0]  y_i,
  output logic [W_IN-1:0]         mag_x_o,
  output logic [W_IN-1:0]         mag_y_o,
  output logic                    neg_o,
  input  logic [W_PROD-1:0]       prod_i,
  input  logic                    prod_neg_i,
  output logic signed [W_ACC-1:0] term_o
);

  logic [W_IN-1:0]  ux;
  logic [W_IN-1:0]  uy;
  logic [W_ACC-1:0] ext;

  // Negating in unsigned arithmetic maps -128 to 8'h80, i.e. magnitude 128.
  assign ux      = x_i;
  assign uy      = y_i;
  assign mag_x_o = x_i[W_IN-1] ? -ux : ux;
  assign mag_y_o = y_i[W_IN-1] ? -uy : uy;
  assign neg_o   = x_i[W_IN-1] ^ y_i[W_IN-1];

  assign ext     = {1'b0, prod_i};
  assign term_o  = prod_neg_i ? -ext : ext;

endmodule

// File: rtl/cmul_scheduler.sv
// Drives one shared 8x8 unsigned multiplier four times to form a signed complex product.
// Latency 1 + 4*(mult latency + 1) + 1; no overlap, in_ready low until the result is taken.
module cmul_scheduler
  import cmul_scheduler_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  cmul_scheduler_if.slave  bus
);

  localparam int DRAIN_W = $clog2(MULT_LAT + 3);
  localparam int TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(MULT_LAT + 2);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);

  state_e                  state_q,  state_d;
  logic [DRAIN_W-1:0]      drain_q,  drain_d;
  logic [TMO_W-1:0]        tmo_q,    tmo_d;
  operands_t               ops_q,    ops_d;
  pp_idx_t                 idx_q,    idx_d;
  logic                    neg_q,    neg_d;
  logic                    err_q,    err_d;
  logic signed [W_ACC-1:0] acc_re_q, acc_re_d;
  logic signed [W_ACC-1:0] acc_im_q, acc_im_d;

  logic signed [W_IN-1:0]  op_x;
  logic signed [W_IN-1:0]  op_y;
  logic [W_IN-1:0]         mag_x;
  logic [W_IN-1:0]         mag_y;
  logic                    pp_neg;
  logic signed [W_ACC-1:0] term;

  always_comb begin
    op_x = sel_a_im(idx_q) ? ops_q.a_im : ops_q.a_re;
    op_y = sel_b_im(idx_q) ? ops_q.b_im : ops_q.b_re;
  end

  cmul_sign_unit u_sign (
    .x_i        (op_x),
    .y_i        (op_y),
    .mag_x_o    (mag_x),
    .mag_y_o    (mag_y),
    .neg_o      (pp_neg),
    .prod_i     (bus.mult_out),
    .prod_neg_i (neg_q),
    .term_o     (term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_DRAIN;
      drain_q  <= DRAIN_INIT;
      tmo_q    <= '0;
      ops_q    <= '0;
      idx_q    <= PP_RR;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      tmo_q    <= tmo_d;
      ops_q    <= ops_d;
      idx_q    <= idx_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    tmo_d    = tmo_q;
    ops_d    = ops_q;
    idx_d    = idx_q;
    neg_d    = neg_q;
    err_d    = err_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;

    case (state_q)
      // The multiplier has no reset, so let any in-flight product flush out first.
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_IDLE;
        else               drain_d = drain_q - DRAIN_W'(1);
      end

      S_IDLE: begin
        if (bus.in_valid) begin
          ops_d    = '{a_re: bus.a_re, a_im: bus.a_im, b_re: bus.b_re, b_im: bus.b_im};
          acc_re_d = '0;
          acc_im_d = '0;
          idx_d    = PP_RR;
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        neg_d   = pp_neg;
        tmo_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bus.mult_valid) begin
          case (acc_op(idx_q))
            ACC_ADD_RE: acc_re_d = acc_re_q + term;
            ACC_SUB_RE: acc_re_d = acc_re_q - term;
            default:    acc_im_d = acc_im_q + term;
          endcase
          state_d = S_GAP;
        end else if (tmo_q == TMO_LAST) begin
          err_d    = 1'b1;
          acc_re_d = '0;
          acc_im_d = '0;
          state_d  = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      // Idle cycle so the multiplier is back at rest before the next start.
      S_GAP: begin
        if (idx_q == PP_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_ISSUE;
        end
      end

      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end

      default: state_d = S_DRAIN;
    endcase
  end

  always_comb begin
    bus.in_ready   = (state_q == S_IDLE);
    bus.out_valid  = (state_q == S_DONE);
    bus.prod_re    = acc_re_q;
    bus.prod_im    = acc_im_q;
    bus.err        = err_q;
    bus.mult_start = (state_q == S_ISSUE);
    bus.mult_a     = '0;
    bus.mult_b     = '0;
    if (state_q == S_ISSUE || state_q == S_WAIT) begin
      bus.mult_a = mag_x;
      bus.mult_b = mag_y;
    end
  end

endmodule

// File: tb/tb_cmul_scheduler.sv
// Bench for cmul_scheduler: behavioural multiplier beside the DUT, scoreboard of
// expected complex products, directed corner cases followed by randomized operations.
module tb_cmul_scheduler;
  import cmul_scheduler_pkg::*;

  localparam int MULT_LAT = 10;
  localparam int TIMEOUT  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmul_scheduler_if bus();

  cmul_scheduler #(.MULT_LAT(MULT_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void ref_cmul(input int ar, input int ai, input int br, input int bi,
                                   output int re, output int im);
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
  endfunction

  // ---------------- multiplier model ----------------
  logic mult_dead = 1'b0;
  logic gap_spur  = 1'b0;
  logic inj_now   = 1'b0;
  int   force_lat = 0;
  int   cd = 0;
  int   tick = 0;
  int   last_real_v = -10;
  int   last_start  = -10;
  int   starts_total = 0;
  logic spur_next = 1'b0;
  logic stale = 1'b0;
  logic [7:0] cap_a, cap_b;

  always @(posedge clk) begin
    #2;
    tick++;
    bus.mult_valid = 1'b0;
    bus.mult_out   = 16'($urandom);
    if (rst) stale = 1'b1;
    if (spur_next) begin
      bus.mult_valid = 1'b1;
      spur_next = 1'b0;
    end
    if (inj_now) bus.mult_valid = 1'b1;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus.mult_valid = 1'b1;
        bus.mult_out   = {8'd0, cap_a} * {8'd0, cap_b};
        last_real_v    = tick;
        if (!stale) begin
          check("mult_a held during wait", bus.mult_a, cap_a);
          check("mult_b held during wait", bus.mult_b, cap_b);
        end
        if (gap_spur) spur_next = 1'b1;
      end
    end
    if (bus.mult_start === 1'b1) begin
      check("start spacing after product", int'(tick - last_real_v >= 2), 1);
      check("start single cycle", int'(tick - last_start >= 2), 1);
      check("start while multiplier busy", cd, 0);
      starts_total++;
      last_start = tick;
      stale = 1'b0;
      if (!mult_dead) begin
        cd    = (force_lat != 0) ? force_lat : $urandom_range(1, MULT_LAT);
        cap_a = bus.mult_a;
        cap_b = bus.mult_b;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  typedef struct {
    int re;
    int im;
    bit err;
    int nstarts;
  } exp_t;

  exp_t q[$];
  bit   err_sticky = 1'b0;
  bit   prev_hold  = 1'b0;
  int   start_base = 0;
  int   done_cnt   = 0;
  int   last_re    = 0;
  int   last_im    = 0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      err_sticky = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check("out_valid with no operation pending", 1, 0);
        end else begin
          check("prod_re", bus.prod_re, q[0].re);
          check("prod_im", bus.prod_im, q[0].im);
          check("err at result", bus.err, q[0].err);
          check("in_ready while result held", bus.in_ready, 0);
          if (bus.out_ready) begin
            check("mult_start count", starts_total - start_base, q[0].nstarts);
            last_re = bus.prod_re;
            last_im = bus.prod_im;
            void'(q.pop_front());
            done_cnt++;
          end
        end
      end else if (prev_hold) begin
        check("out_valid dropped before accept", 0, 1);
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        if (mult_dead) begin
          e.re = 0;
          e.im = 0;
          e.nstarts = 1;
          err_sticky = 1'b1;
        end else begin
          ref_cmul(bus.a_re, bus.a_im, bus.b_re, bus.b_im, e.re, e.im);
          e.nstarts = 4;
        end
        e.err = err_sticky;
        q.push_back(e);
        start_base = starts_total;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ar, input int ai, input int br, input int bi);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (bus.in_ready !== 1'b1) check("in_ready wait timed out", 0, 1);
    bus.a_re = 8'(ar);
    bus.a_im = 8'(ai);
    bus.b_re = 8'(br);
    bus.b_im = 8'(bi);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_bp);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin
      bus.out_ready = rand_bp ? 1'($urandom % 2) : 1'b1;
      step();
      n++;
    end
    bus.out_ready = 1'b1;
    if (done_cnt == start) check("operation completion timed out", 0, 1);
  endtask

  task automatic run(input string name, input int ar, input int ai, input int br, input int bi,
                     input int exp_re, input int exp_im);
    int mre, mim;
    int d0 = done_cnt;
    ref_cmul(ar, ai, br, bi, mre, mim);
    check({name, " model re"}, mre, exp_re);
    check({name, " model im"}, mim, exp_im);
    send(ar, ai, br, bi);
    wait_done(300, 1'b0);
    check({name, " re"}, last_re, exp_re);
    check({name, " im"}, last_im, exp_im);
    check({name, " results delivered"}, done_cnt - d0, 1);
  endtask

  function automatic int rnd8();
    int v;
    case ($urandom % 5)
      0:       v = -128;
      1:       v = 127;
      default: v = int'($urandom_range(0, 255)) - 128;
    endcase
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0;
    repeat (3) step();
    check("reset in_ready", bus.in_ready, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset prod_re", bus.prod_re, 0);
    check("reset prod_im", bus.prod_im, 0);
    check("reset err", bus.err, 0);
    check("reset mult_start", bus.mult_start, 0);
    check("reset mult_a", bus.mult_a, 0);
    check("reset mult_b", bus.mult_b, 0);
    rst = 1'b0;
    for (int i = 0; i < MULT_LAT + 2; i++) begin
      check("in_ready during drain", bus.in_ready, 0);
      step();
    end

    run("basic", 3, 4, 2, -1, 10, 5);
    run("extreme", -128, -128, -128, 127, 32640, 128);
    run("real only", -128, 0, -128, 0, 16384, 0);

    // Backpressure with a competing request that must be ignored.
    bus.out_ready = 1'b0;
    send(5, -7, -3, 2);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin step(); n++; end
    check("backpressure result appears", bus.out_valid, 1);
    for (int i = 0; i < 20; i++) begin
      bus.a_re = 8'(i); bus.a_im = 8'(-i); bus.b_re = 8'd9; bus.b_im = 8'd1;
      bus.in_valid = 1'b1;
      step();
      check("bp out_valid held", bus.out_valid, 1);
      check("bp prod_re", bus.prod_re, -1);
      check("bp prod_im", bus.prod_im, 31);
    end
    bus.in_valid = 1'b0;
    wait_done(20, 1'b0);
    check("bp accepted re", last_re, -1);
    run("after backpressure", -2, 3, 4, -5, 7, 22);

    // Spurious product pulses in IDLE and in GAP.
    inj_now = 1'b1; step(); inj_now = 1'b0; step();
    gap_spur = 1'b1;
    run("spurious valid", 7, -1, -6, 9, -33, 69);
    gap_spur = 1'b0;

    // Multiplier that never answers.
    mult_dead = 1'b1;
    send(1, 2, 3, 4);
    wait_done(400, 1'b0);
    check("timeout err", bus.err, 1);
    check("timeout re", last_re, 0);
    check("timeout im", last_im, 0);
    mult_dead = 1'b0;
    run("after timeout", 2, 0, 0, 3, 0, 6);
    check("err sticky", bus.err, 1);

    // Reset while the third partial product is outstanding.
    force_lat = MULT_LAT;
    send(9, -4, 6, 11);
    n = 0;
    while (starts_total - start_base < 3 && n < 200) begin step(); n++; end
    check("third partial product issued", int'(starts_total - start_base >= 3), 1);
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    force_lat = 0;
    for (int i = 0; i < MULT_LAT + 2; i++) begin
      inj_now = (i == 4);
      check("in_ready after mid-op reset", bus.in_ready, 0);
      step();
    end
    inj_now = 1'b0;
    check("err cleared by reset", bus.err, 0);
    run("after reset", 1, 1, 1, 1, 0, 2);

    // Randomized operations with random latency and random consumer stalls.
    for (int i = 0; i < 30; i++) begin
      send(rnd8(), rnd8(), rnd8(), rnd8());
      wait_done(600, 1'($urandom % 2));
      repeat ($urandom_range(0, 3)) step();
    end

    check("scoreboard drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
